// File: rtl/jpeg_huffman_decoder_mt.sv
// jpeg_huffman_decoder_mt: multi-table canonical Huffman symbol decoder.
// Tables are loaded straight from DHT segment bytes (16 BITS counts, then
// HUFFVAL). For each table and code length the loader keeps MINCODE (low
// byte), MAXCODE, VALPTR and a present flag. Decoding shifts bits in MSB
// first, compares against MAXCODE, then reads HUFFVAL through a registered
// lookup stage.
module jpeg_huffman_decoder_mt #(
  parameter int NUM_TABLES   = 4,
  parameter int TID_W        = 2,
  parameter int MAX_CODE_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TID_W-1:0]      cfg_table,
  input  logic [7:0]            cfg_byte,
  output logic                  cfg_error,
  output logic [NUM_TABLES-1:0] table_loaded,
  input  logic [TID_W-1:0]      dec_table,
  input  logic                  flush,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [7:0]            symbol_out,
  output logic [4:0]            symbol_len,
  output logic                  symbol_valid,
  input  logic                  symbol_ready,
  output logic                  dec_error
);

  localparam int NT = 1 << TID_W;
  localparam int LA_W = TID_W + 4;
  localparam int VA_W = TID_W + 8;
  localparam logic [4:0] MAX_LEN_C = 5'(MAX_CODE_LEN);

  typedef enum logic [1:0] {CFG_IDLE, CFG_BITS, CFG_VALS} cfg_state_e;
  typedef enum logic [1:0] {D_IDLE, D_SHIFT, D_LOOKUP, D_OUT} dec_state_e;

  // Per-table, per-length decode parameters, addressed {table, L-1}.
  // Only the low byte of MINCODE is kept: the HUFFVAL index is always
  // below 256, so modulo-256 arithmetic gives the exact result.
  logic [7:0]  mincode_mem [NT*16];
  logic [15:0] maxcode_mem [NT*16];
  logic [7:0]  valptr_mem  [NT*16];
  logic        present_mem [NT*16];
  logic [7:0]  huffval_mem [NT*256];

  // Config state
  cfg_state_e       cfg_state_q, cfg_state_d;
  logic [TID_W-1:0] cfg_tid_q, cfg_tid_d;
  logic [4:0]       cfg_len_q, cfg_len_d;
  logic [17:0]      cfg_code_q, cfg_code_d;
  logic [8:0]       cfg_k_q, cfg_k_d;
  logic [8:0]       cfg_idx_q, cfg_idx_d;
  logic [NT-1:0]    table_loaded_q, table_loaded_d;
  logic             cfg_error_q, cfg_error_d;

  // Decode state
  dec_state_e       dec_state_q, dec_state_d;
  logic [14:0]      code_q, code_d;
  logic [4:0]       len_q, len_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       sym_q, sym_d;
  logic             dec_error_q, dec_error_d;

  // Config datapath helpers
  logic             cfg_fire_s;
  logic [4:0]       cur_len_s;
  logic [17:0]      cur_code_s;
  logic [8:0]       cur_k_s;
  logic [TID_W-1:0] cur_tid_s;
  logic [18:0]      sum_s;
  logic [18:0]      limit_s;
  logic [9:0]       k_sum_s;
  logic             ovf_s;

  // Storage write strobes
  logic             lt_we_s;
  logic [LA_W-1:0]  lt_addr_s;
  logic [7:0]       lt_min_s;
  logic [15:0]      lt_max_s;
  logic [7:0]       lt_ptr_s;
  logic             lt_pres_s;
  logic             hv_we_s;
  logic [VA_W-1:0]  hv_addr_s;
  logic [7:0]       hv_data_s;

  // Decode datapath helpers
  logic             bit_ready_s;
  logic             bit_fire_s;
  logic [15:0]      sh_code_s;
  logic [4:0]       sh_len_s;
  logic [TID_W-1:0] sh_tid_s;
  logic [LA_W-1:0]  sh_addr_s;
  logic             match_s;
  logic [7:0]       idx_s;

  // Config may only be taken while no code is in flight.
  assign cfg_ready    = (dec_state_q == D_IDLE);
  assign cfg_fire_s   = cfg_valid && cfg_ready;
  assign cfg_error    = cfg_error_q;
  assign table_loaded = table_loaded_q[NUM_TABLES-1:0];

  assign bit_ready    = bit_ready_s;
  assign bit_fire_s   = bit_valid && bit_ready_s;
  assign symbol_valid = (dec_state_q == D_OUT);
  assign symbol_out   = sym_q;
  assign symbol_len   = symbol_valid ? len_q : 5'd0;
  assign dec_error    = dec_error_q;

  // The first BITS byte arrives in CFG_IDLE, so it acts as length 1 with
  // code and k starting from zero.
  assign cur_len_s  = (cfg_state_q == CFG_IDLE) ? 5'd1 : cfg_len_q;
  assign cur_code_s = (cfg_state_q == CFG_IDLE) ? 18'd0 : cfg_code_q;
  assign cur_k_s    = (cfg_state_q == CFG_IDLE) ? 9'd0 : cfg_k_q;
  assign cur_tid_s  = (cfg_state_q == CFG_IDLE) ? cfg_table : cfg_tid_q;
  assign sum_s      = {1'b0, cur_code_s} + {11'd0, cfg_byte};
  assign limit_s    = 19'd1 << cur_len_s;
  assign k_sum_s    = {1'b0, cur_k_s} + {2'd0, cfg_byte};
  assign ovf_s      = (sum_s > limit_s) || (k_sum_s > 10'd256) ||
                      ((cur_len_s > MAX_LEN_C) && (cfg_byte != 8'd0));

  // Candidate code after shifting in the offered bit; table comes from
  // dec_table on the first bit and from the latched id afterwards.
  assign sh_code_s = {code_q, bit_in};
  assign sh_len_s  = len_q + 5'd1;
  assign sh_tid_s  = (dec_state_q == D_IDLE) ? dec_table : tid_q;
  assign sh_addr_s = {sh_tid_s, len_q[3:0]};
  assign match_s   = present_mem[sh_addr_s] && (sh_code_s <= maxcode_mem[sh_addr_s]);
  assign idx_s     = valptr_mem[sh_addr_s] + sh_code_s[7:0] - mincode_mem[sh_addr_s];

  // Config FSM: walk the 16 BITS counts, then store HUFFVAL bytes.
  always_comb begin
    cfg_state_d    = cfg_state_q;
    cfg_tid_d      = cfg_tid_q;
    cfg_len_d      = cfg_len_q;
    cfg_code_d     = cfg_code_q;
    cfg_k_d        = cfg_k_q;
    cfg_idx_d      = cfg_idx_q;
    table_loaded_d = table_loaded_q;
    cfg_error_d    = 1'b0;
    lt_we_s        = 1'b0;
    lt_addr_s      = {cur_tid_s, 4'(cur_len_s - 5'd1)};
    lt_min_s       = cur_code_s[7:0];
    lt_max_s       = 16'(sum_s - 19'd1);
    lt_ptr_s       = cur_k_s[7:0];
    lt_pres_s      = (cfg_byte != 8'd0);
    hv_we_s        = 1'b0;
    hv_addr_s      = {cfg_tid_q, cfg_idx_q[7:0]};
    hv_data_s      = cfg_byte;
    case (cfg_state_q)
      CFG_IDLE, CFG_BITS: begin
        if (cfg_fire_s) begin
          if (cfg_state_q == CFG_IDLE) begin
            cfg_tid_d                 = cfg_table;
            table_loaded_d[cfg_table] = 1'b0;
          end else begin
            cfg_tid_d = cfg_tid_q;
          end
          lt_we_s = 1'b1;
          if (ovf_s) begin
            cfg_error_d = 1'b1;
            cfg_state_d = CFG_IDLE;
          end else if (cur_len_s == 5'd16) begin
            if (k_sum_s == 10'd0) begin
              table_loaded_d[cur_tid_s] = 1'b1;
              cfg_state_d               = CFG_IDLE;
            end else begin
              cfg_state_d = CFG_VALS;
              cfg_idx_d   = 9'd0;
              cfg_k_d     = k_sum_s[8:0];
            end
          end else begin
            cfg_state_d = CFG_BITS;
            cfg_len_d   = cur_len_s + 5'd1;
            cfg_code_d  = {sum_s[16:0], 1'b0};
            cfg_k_d     = k_sum_s[8:0];
          end
        end else begin
          cfg_state_d = cfg_state_q;
        end
      end
      CFG_VALS: begin
        if (cfg_fire_s) begin
          hv_we_s = 1'b1;
          if (cfg_idx_q == (cfg_k_q - 9'd1)) begin
            table_loaded_d[cfg_tid_q] = 1'b1;
            cfg_state_d               = CFG_IDLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 9'd1;
          end
        end else begin
          cfg_state_d = cfg_state_q;
        end
      end
      default: begin
        cfg_state_d = CFG_IDLE;
      end
    endcase
  end

  // Bit acceptance: a new code needs a loaded table and an idle loader;
  // flush always blocks the bit offered in the same cycle.
  always_comb begin
    bit_ready_s = 1'b0;
    case (dec_state_q)
      D_IDLE:  bit_ready_s = !flush && (cfg_state_q == CFG_IDLE) && !cfg_valid &&
                             table_loaded_q[dec_table];
      D_SHIFT: bit_ready_s = !flush;
      default: bit_ready_s = 1'b0;
    endcase
  end

  // Decode FSM: shift/compare, registered HUFFVAL read, hold until taken.
  always_comb begin
    dec_state_d = dec_state_q;
    code_d      = code_q;
    len_d       = len_q;
    tid_d       = tid_q;
    idx_d       = idx_q;
    sym_d       = sym_q;
    dec_error_d = 1'b0;
    case (dec_state_q)
      D_IDLE, D_SHIFT: begin
        if (flush) begin
          code_d      = 15'd0;
          len_d       = 5'd0;
          dec_state_d = D_IDLE;
        end else if (bit_fire_s) begin
          tid_d  = sh_tid_s;
          code_d = sh_code_s[14:0];
          len_d  = sh_len_s;
          if (match_s) begin
            idx_d       = idx_s;
            dec_state_d = D_LOOKUP;
          end else if (sh_len_s >= MAX_LEN_C) begin
            dec_error_d = 1'b1;
            code_d      = 15'd0;
            len_d       = 5'd0;
            dec_state_d = D_IDLE;
          end else begin
            dec_state_d = D_SHIFT;
          end
        end else begin
          dec_state_d = dec_state_q;
        end
      end
      D_LOOKUP: begin
        sym_d       = huffval_mem[{tid_q, idx_q}];
        dec_state_d = D_OUT;
      end
      D_OUT: begin
        if (symbol_ready) begin
          code_d      = 15'd0;
          len_d       = 5'd0;
          dec_state_d = D_IDLE;
        end else begin
          dec_state_d = D_OUT;
        end
      end
      default: begin
        code_d      = 15'd0;
        len_d       = 5'd0;
        dec_state_d = D_IDLE;
      end
    endcase
  end

  // Control and datapath registers; reset aborts any load and unloads all tables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_state_q    <= CFG_IDLE;
      cfg_tid_q      <= '0;
      cfg_len_q      <= 5'd0;
      cfg_code_q     <= 18'd0;
      cfg_k_q        <= 9'd0;
      cfg_idx_q      <= 9'd0;
      table_loaded_q <= '0;
      cfg_error_q    <= 1'b0;
      dec_state_q    <= D_IDLE;
      code_q         <= 15'd0;
      len_q          <= 5'd0;
      tid_q          <= '0;
      idx_q          <= 8'd0;
      sym_q          <= 8'd0;
      dec_error_q    <= 1'b0;
    end else begin
      cfg_state_q    <= cfg_state_d;
      cfg_tid_q      <= cfg_tid_d;
      cfg_len_q      <= cfg_len_d;
      cfg_code_q     <= cfg_code_d;
      cfg_k_q        <= cfg_k_d;
      cfg_idx_q      <= cfg_idx_d;
      table_loaded_q <= table_loaded_d;
      cfg_error_q    <= cfg_error_d;
      dec_state_q    <= dec_state_d;
      code_q         <= code_d;
      len_q          <= len_d;
      tid_q          <= tid_d;
      idx_q          <= idx_d;
      sym_q          <= sym_d;
      dec_error_q    <= dec_error_d;
    end
  end

  // Table storage; contents are qualified by table_loaded, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lt_we_s) begin
      mincode_mem[lt_addr_s] <= lt_min_s;
      maxcode_mem[lt_addr_s] <= lt_max_s;
      valptr_mem[lt_addr_s]  <= lt_ptr_s;
      present_mem[lt_addr_s] <= lt_pres_s;
    end
    if (hv_we_s) begin
      huffval_mem[hv_addr_s] <= hv_data_s;
    end
  end

endmodule

// File: tb/tb_jpeg_huffman_decoder_mt.sv
// Testbench for jpeg_huffman_decoder_mt: directed scenarios plus random
// decodes checked against a symbol-list model built from the BITS/HUFFVAL
// definition of canonical JPEG codes.
module tb_jpeg_huffman_decoder_mt;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_table;
  logic [7:0] cfg_byte;
  logic       cfg_error;
  logic [3:0] table_loaded;
  logic [1:0] dec_table;
  logic       flush;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] symbol_out;
  logic [4:0] symbol_len;
  logic       symbol_valid;
  logic       symbol_ready;
  logic       dec_error;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus tables and the per-table symbol-list model
  int   tb_bits [4][16];
  int   tb_vals [4][256];
  int   m_n     [4];
  int   m_code  [4][256];
  int   m_len   [4][256];
  int   m_val   [4][256];
  logic [3:0] m_loaded;

  always #5 clk = ~clk;

  jpeg_huffman_decoder_mt #(.NUM_TABLES(4), .TID_W(2), .MAX_CODE_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_table(cfg_table), .cfg_byte(cfg_byte), .cfg_error(cfg_error),
    .table_loaded(table_loaded), .dec_table(dec_table), .flush(flush),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .symbol_out(symbol_out), .symbol_len(symbol_len), .symbol_valid(symbol_valid),
    .symbol_ready(symbol_ready), .dec_error(dec_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Canonical code assignment: consecutive codes within a length, shift between lengths.
  task automatic build_model(input int t);
    int code;
    int k;
    code = 0;
    k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < tb_bits[t][l-1]; j++) begin
        m_code[t][k] = code;
        m_len[t][k]  = l;
        m_val[t][k]  = tb_vals[t][k];
        k++;
        code++;
      end
      code = code << 1;
    end
    m_n[t] = k;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    chk({tag, "_cfg_error"}, {31'd0, cfg_error}, 32'd0);
    chk({tag, "_loaded"}, {28'd0, table_loaded}, 32'd0);
    chk({tag, "_bit_ready"}, {31'd0, bit_ready}, 32'd0);
    chk({tag, "_sym_valid"}, {31'd0, symbol_valid}, 32'd0);
    chk({tag, "_sym_out"}, {24'd0, symbol_out}, 32'd0);
    chk({tag, "_sym_len"}, {27'd0, symbol_len}, 32'd0);
    chk({tag, "_dec_error"}, {31'd0, dec_error}, 32'd0);
  endtask

  // All drive tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    logic acc;
    cfg_byte  = b;
    cfg_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      #1 acc = cfg_ready;
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        n++;
      end
    end
    if (!acc) chk("cfg_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_bit(input int t, input logic b);
    int n;
    logic acc;
    dec_table = 2'(t);
    bit_in    = b;
    bit_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      #1 acc = bit_ready;
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        n++;
      end
    end
    if (!acc) chk("bit_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic load_table(input int t);
    int total;
    cfg_table = 2'(t);
    m_loaded[t] = 1'b0;
    total = 0;
    for (int l = 0; l < 16; l++) begin
      send_byte(8'(tb_bits[t][l]));
      total += tb_bits[t][l];
    end
    for (int i = 0; i < total; i++) send_byte(8'(tb_vals[t][i]));
    build_model(t);
    m_loaded[t] = 1'b1;
    chk("load_err", {31'd0, cfg_error}, 32'd0);
    chk("loaded", {28'd0, table_loaded}, {28'd0, m_loaded});
  endtask

  // Send one code, then check latency, backpressure hold and handshake.
  task automatic do_code(input int t, input int code, input int len, input int exp_sym,
                         input int stall);
    for (int i = len - 1; i >= 0; i--) send_bit(t, code[i]);
    chk("lat_lookup", {31'd0, symbol_valid}, 32'd0);
    @(negedge clk);
    chk("sym_valid", {31'd0, symbol_valid}, 32'd1);
    chk("sym_out", {24'd0, symbol_out}, 32'(exp_sym));
    chk("sym_len", {27'd0, symbol_len}, 32'(len));
    dec_table = 2'(t);
    bit_in    = 1'($urandom_range(0, 1));
    bit_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      #1;
      chk("bp_valid", {31'd0, symbol_valid}, 32'd1);
      chk("bp_sym", {24'd0, symbol_out}, 32'(exp_sym));
      chk("bp_bit_ready", {31'd0, bit_ready}, 32'd0);
      @(negedge clk);
    end
    symbol_ready = 1'b1;
    #1;
    chk("hs_sym", {24'd0, symbol_out}, 32'(exp_sym));
    @(posedge clk);
    @(negedge clk);
    symbol_ready = 1'b0;
    bit_valid    = 1'b0;
    chk("hs_done", {31'd0, symbol_valid}, 32'd0);
  endtask

  // Random valid table: at most 3 codes per length, never over-subscribed.
  task automatic gen_random_table(input int t);
    int code;
    int total;
    int avail;
    int c;
    code = 0;
    total = 0;
    for (int l = 1; l <= 16; l++) begin
      avail = (1 << l) - code;
      c = $urandom_range(0, 3);
      if (c > avail) c = avail;
      tb_bits[t][l-1] = c;
      total += c;
      code = (code + c) << 1;
    end
    if (total == 0) begin
      tb_bits[t][15] = 1;
      total = 1;
    end
    for (int i = 0; i < total; i++) tb_vals[t][i] = $urandom_range(0, 255);
  endtask

  initial begin
    int t;
    int i;
    rst_n        = 1'b0;
    cfg_valid    = 1'b0;
    cfg_table    = 2'd0;
    cfg_byte     = 8'd0;
    dec_table    = 2'd0;
    flush        = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    symbol_ready = 1'b0;
    m_loaded     = 4'd0;
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: table 0
    tb_bits[0] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int v = 0; v < 12; v++) tb_vals[0][v] = v;
    load_table(0);
    chk("t1_loaded", {28'd0, table_loaded}, 32'h1);
    do_code(0, 0, 2, 8'h00, 0);
    do_code(0, 6, 3, 8'h05, 0);
    do_code(0, 9'h1FE, 9, 8'h0B, 1);

    // 2: table 1, alternating tables
    tb_bits[1] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tb_vals[1][0] = 8'h0A;
    tb_vals[1][1] = 8'h0B;
    tb_vals[1][2] = 8'h0C;
    load_table(1);
    do_code(1, 0, 1, 8'h0A, 0);
    do_code(1, 2, 2, 8'h0B, 0);
    do_code(0, 0, 2, 8'h00, 0);
    do_code(1, 6, 3, 8'h0C, 0);

    // 3: backpressure, then the next code right after
    do_code(0, 6, 3, 8'h05, 5);
    do_code(0, 0, 2, 8'h00, 0);

    // 4: sixteen ones on table 0 -> dec_error, then 00 still decodes
    for (int b = 0; b < 15; b++) begin
      send_bit(0, 1'b1);
      chk("no_dec_err", {31'd0, dec_error}, 32'd0);
    end
    send_bit(0, 1'b1);
    chk("dec_err_pulse", {31'd0, dec_error}, 32'd1);
    chk("dec_err_nosym", {31'd0, symbol_valid}, 32'd0);
    @(negedge clk);
    chk("dec_err_clear", {31'd0, dec_error}, 32'd0);
    do_code(0, 0, 2, 8'h00, 0);
    // flush a partial code
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    flush     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    #1 chk("flush_blocks_bit", {31'd0, bit_ready}, 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    bit_valid = 1'b0;
    do_code(0, 2, 3, 8'h01, 1);

    // 5: bad table 2 (three codes of length 1)
    cfg_table = 2'd2;
    send_byte(8'd3);
    chk("cfg_err_pulse", {31'd0, cfg_error}, 32'd1);
    @(negedge clk);
    chk("cfg_err_clear", {31'd0, cfg_error}, 32'd0);
    chk("bad_not_loaded", {28'd0, table_loaded}, 32'h3);
    dec_table = 2'd2;
    bit_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1 chk("bad_bit_ready", {31'd0, bit_ready}, 32'd0);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    do_code(1, 0, 1, 8'h0A, 0);

    // Random tables 3 and 1, then random decodes with random backpressure
    gen_random_table(3);
    load_table(3);
    gen_random_table(1);
    load_table(1);
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 2))
        0: t = 0;
        1: t = 1;
        default: t = 3;
      endcase
      i = $urandom_range(0, m_n[t] - 1);
      do_code(t, m_code[t][i], m_len[t][i], m_val[t][i], $urandom_range(0, 2));
    end

    // 6: reset mid-code and mid-load
    send_bit(0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_code");
    m_loaded = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dec_table = 2'd0;
    bit_valid = 1'b1;
    #1 chk("rst_no_table", {31'd0, bit_ready}, 32'd0);
    @(negedge clk);
    bit_valid = 1'b0;
    cfg_table = 2'd0;
    send_byte(8'd0);
    send_byte(8'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_table(0);
    do_code(0, 6, 3, 8'h05, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jpeg_huffman_decoder_mt.md
Name: jpeg_huffman_decoder_mt

Overview:
- Multi-table canonical Huffman symbol decoder for the JPEG entropy-decode path.
- Successor to the single-table bit-serial decoder.
- Tables load directly from DHT segment bytes (16 BITS counts followed by HUFFVAL). Decode derives MINCODE/MAXCODE/VALPTR per code length internally, so no flattened code/length arrays are needed.
- NUM_TABLES independent tables (DC/AC × luma/chroma); each symbol can decode from any loaded table.
- Ready/valid handshakes on configuration, bit and symbol interfaces; flush input and error reporting.

Parameters:
- NUM_TABLES, 4, number of independent Huffman tables.
- TID_W, 2, table-select width; must satisfy 2**TID_W >= NUM_TABLES.
- MAX_CODE_LEN, 16, longest legal code length in bits (JPEG value; range 1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config byte valid.
- cfg_ready  out  1  config byte accepted when both valid and ready are high.
- cfg_table  in  TID_W  target table; sampled on the first byte of a segment.
- cfg_byte  in  8  BITS count (bytes 1..16), then HUFFVAL symbols.
- cfg_error  out  1  one-cycle pulse: malformed table.
- table_loaded  out  NUM_TABLES  per-table valid flags.
- dec_table  in  TID_W  table used for the next code; sampled when the first bit of a code is accepted.
- flush  in  1  discard partial code; return to idle.
- bit_in  in  1  serial code bit, MSB first.
- bit_valid  in  1  bit valid.
- bit_ready  out  1  bit accepted when both valid and ready are high.
- symbol_out  out  8  decoded symbol.
- symbol_len  out  5  code length of the decoded symbol.
- symbol_valid  out  1  symbol available; held until symbol_ready.
- symbol_ready  in  1  downstream accepts symbol.
- dec_error  out  1  one-cycle pulse: no code matched by MAX_CODE_LEN bits.

Behaviour:
- Reset values:
  - All outputs 0, except cfg_ready=1.
  - table_loaded=0, decoder IDLE, code/len registers 0.
  - Reset mid-load or mid-decode aborts the operation and clears all tables.
- Config FSM, states CFG_IDLE → CFG_BITS → CFG_VALS → CFG_IDLE:
  - First accepted byte starts CFG_BITS. Latch cfg_table and clear table_loaded[cfg_table].
  - CFG_BITS processes one byte per accepted handshake for L=1..16, with code=0 and k=0 initially:
    - mincode[L]=code, valptr[L]=k.
    - If count>0: maxcode[L]=code+count-1, present[L]=1; otherwise present[L]=0.
    - Then code=(code+count)<<1 and k+=count.
  - Overflow error: code+count > 2**L, or L > MAX_CODE_LEN with a nonzero count.
  - After byte 16: if total=0, finish immediately. Otherwise enter CFG_VALS.
  - CFG_VALS stores HUFFVAL[0..total-1]. After the last value: table_loaded[t]=1, return to CFG_IDLE.
  - Total > 256 is an error.
  - On any error: pulse cfg_error, leave the table unloaded, return to CFG_IDLE, and drop the rest of the segment.
- cfg_ready=0 while a code is partially received or a symbol is pending/being looked up.
- bit_ready=0 while the config FSM is not in CFG_IDLE.
- Decode FSM, states D_IDLE, D_SHIFT, D_LOOKUP, D_OUT:
  - D_IDLE: bit_ready=1 only if table_loaded[dec_table]=1; otherwise stall, no error.
  - Each accepted bit: code={code,bit_in}, len=len+1. Table t is latched on the first bit.
  - Match when present[len] and code<=maxcode[len] (code>=mincode[len] holds by construction). On match, enter D_LOOKUP with index valptr[len]+code-mincode[len].
  - D_LOOKUP: registered HUFFVAL read, one cycle, bit_ready=0.
  - D_OUT: symbol_valid=1, with symbol_out/symbol_len stable until symbol_ready. Back to D_IDLE on handshake, with code and len cleared.
  - Latency: symbol_valid asserts 2 cycles after the final bit is accepted.
  - Peak throughput: one symbol per (len+2) cycles.
- No match with len==MAX_CODE_LEN: pulse dec_error, clear code/len, go to D_IDLE.
- flush:
  - Highest priority in D_SHIFT/D_IDLE: clears code/len. A bit presented in the same cycle is not accepted (bit_ready=0).
  - Flush in D_LOOKUP/D_OUT is ignored; the symbol still completes.
- Reloading a table is allowed only while decode is idle.
- Other tables stay usable after a failed load of one table.

Test Plan:
1. Load table 0:
   - Stimulus: BITS {0,1,5,1,1,1,1,1,1,0×7}, HUFFVAL 0x00..0x0B.
   - Required: table_loaded=4'b0001.
   - Bits 00 → sym 0x00 len 2.
   - Bits 110 → 0x05 len 3.
   - Bits 111111110 → 0x0B len 9.
2. Load table 1:
   - Stimulus: BITS {1,1,1,0×13}, HUFFVAL {0x0A,0x0B,0x0C}.
   - Alternate dec_table between 1 and 0.
   - Table 1, bits 0 → 0x0A; table 1, bits 10 → 0x0B; table 0, bits 00 → 0x00; table 1, bits 110 → 0x0C.
3. Backpressure:
   - Stimulus: hold symbol_ready=0 for 5 cycles after symbol_valid.
   - Required: symbol held stable, bit_ready=0 throughout.
   - Next code's bits are accepted only after the handshake, and no symbol is lost.
4. Error and flush:
   - Table 0 fed sixteen 1 bits → dec_error pulses on the 16th bit. A following 00 decodes to 0x00.
   - bits 11, then flush, then 010 → 0x01.
5. Bad table:
   - Stimulus: load table 2 with BITS L1=3.
   - Required: cfg_error pulse, table_loaded[2]=0.
   - dec_table=2 → bit_ready stays 0.
6. Reset:
   - Stimulus: assert rst_n low mid-code and mid-load.
   - Required: all outputs at reset values, table_loaded=0.
